toplevel_alu: RTL and testbench
===============================

# toplevel_alu

Datapath slice with two 16-bit operand registers (R0, R1), a combinational 8-function ALU, a 16-bit result register (R2), and a tri-state driver onto a shared 16-bit bus. Operands load from the bus. The ALU result is captured into R2 and can be driven back onto the bus. The block sits under the microcontroller control unit, which sequences the enables and ALU_Sel; all internal nodes are exported as ports for observation.

## Interface
- No parameters. Data width fixed at 16 bits, opcode width fixed at 3 bits.
- One clock; reset is synchronous and active-high.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- r0en  input  1  load enable for R0 from bus.
- r1en  input  1  load enable for R1 from bus.
- r0toalu  output  16  current R0 contents (ALU operand A).
- r1toalu  output  16  current R1 contents (ALU operand B).
- ALU_Sel  input  3  ALU function select.
- resulttoreg  output  16  combinational ALU result (R2 input).
- r2en  input  1  load enable for R2 from resulttoreg.
- r2tobuff_alu  output  16  current R2 contents (tri-state buffer input).
- bus  inout  16  shared system bus.
- aluOutEn  input  1  drives R2 onto bus when 1; otherwise bus output is high-Z.

## Operation
- The ALU is combinational with A = R0 and B = R1. All results are truncated to 16 bits; carry and borrow are discarded.
- ALU_Sel 000: A + B.
- ALU_Sel 001: A - B (two's complement, wraps).
- ALU_Sel 010: A & B.
- ALU_Sel 011: A | B.
- ALU_Sel 100: A ^ B.
- ALU_Sel 101: ~A.
- ALU_Sel 110: A << 1 (LSB filled with 0).
- ALU_Sel 111: A >> 1 (logical; MSB filled with 0).
- R0 and R1 load the value on bus on a clock edge when their enable is high; otherwise they hold.
- R2 loads resulttoreg on a clock edge when r2en is high; otherwise it holds.
- bus is driven with R2 when aluOutEn = 1, else released (all bits Z).
- External drivers own the bus when aluOutEn = 0. The block never drives the bus otherwise.
- Simultaneous aluOutEn = 1 and r0en/r1en = 1: the register loads R2 via the bus. This is a legal register-transfer path.
- r0en and r1en both high: both registers load the same bus value.
- Loading from an undriven bus captures Z/X. Avoiding this is the controller's responsibility; the block performs no checking.
- No flags and no internal state machine.

## Timing
- Reset: on a rising edge with rst = 1, R0, R1 and R2 all become 0x0000.
  - r0toalu, r1toalu and r2tobuff_alu therefore read 0x0000, and resulttoreg reflects the ALU on zeros (e.g. 0x0000 for ADD, 0xFFFF for NOT).
- rst has priority over every enable in the same cycle. Reset mid-operation discards any pending loads.
- Register load latency: 1 cycle. The new value is visible on r0toalu, r1toalu or r2tobuff_alu right after the enabling edge.
- resulttoreg follows R0, R1 and ALU_Sel combinationally in the same cycle.
- Bus drive and release are combinational from aluOutEn, with no clock latency.
- Full-pipeline latency:
  - operand load edge N;
  - r2en edge N+1 captures the result;
  - aluOutEn in cycle N+1 onward presents it on the bus.
- Enables are sampled only at rising edges; glitches between edges have no effect.

## Test plan
- Reset: hold rst = 1 for one edge after arbitrary loads -> R0 = R1 = R2 = 0x0000 and bus = Z with aluOutEn = 0.
- Load/add: bench drives bus = 0x1234 with r0en, then 0x0F0F with r1en, then ALU_Sel = 000 with r2en -> resulttoreg = 0x2143; after aluOutEn = 1 and bench release, bus = 0x2143.
- Opcode sweep: R0 = 0x8001, R1 = 0x0003; step ALU_Sel 000..111 -> 0x8004, 0x7FFE, 0x0001, 0x8003, 0x8002, 0x7FFE, 0x0002, 0x4000.
- Wrap: R0 = 0xFFFF, R1 = 0x0001 -> ADD = 0x0000; SUB with R0 = 0x0000, R1 = 0x0001 -> 0xFFFF.
- Hold/transfer: R2 = 0x00AA; aluOutEn = 1 with r1en = 1 for one edge -> R1 = 0x00AA; with r2en = 0, R2 holds while operands change.
- Reset priority: rst = 1 together with r0en/r2en set and bus = 0x5555 -> all registers 0x0000 after the edge.

Source files
------------

// File: rtl/toplevel_alu.sv
// Datapath slice: two operand registers loaded from a shared bus, an 8-function ALU,
// a result register, and a tri-state driver returning the result to the bus.
module toplevel_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0en,
    input  logic        r1en,
    output logic [15:0] r0toalu,
    output logic [15:0] r1toalu,
    input  logic [2:0]  ALU_Sel,
    output logic [15:0] resulttoreg,
    input  logic        r2en,
    output logic [15:0] r2tobuff_alu,
    inout  wire  [15:0] bus,
    input  logic        aluOutEn
);

    localparam int unsigned DATA_W = 16;

    logic [DATA_W-1:0] r0_q;
    logic [DATA_W-1:0] r1_q;
    logic [DATA_W-1:0] r2_q;
    logic [DATA_W-1:0] alu_c;

    // Operand and result registers; reset wins over every enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_q <= '0;
            r1_q <= '0;
            r2_q <= '0;
        end else begin
            if (r0en) r0_q <= bus;
            if (r1en) r1_q <= bus;
            if (r2en) r2_q <= alu_c;
        end
    end

    // Combinational ALU, A = R0, B = R1; carries and borrows are dropped
    always_comb begin
        alu_c = '0;
        case (ALU_Sel)
            3'b000:  alu_c = DATA_W'(r0_q + r1_q);
            3'b001:  alu_c = DATA_W'(r0_q - r1_q);
            3'b010:  alu_c = r0_q & r1_q;
            3'b011:  alu_c = r0_q | r1_q;
            3'b100:  alu_c = r0_q ^ r1_q;
            3'b101:  alu_c = ~r0_q;
            3'b110:  alu_c = {r0_q[DATA_W-2:0], 1'b0};
            3'b111:  alu_c = {1'b0, r0_q[DATA_W-1:1]};
            default: alu_c = '0;
        endcase
    end

    assign r0toalu      = r0_q;
    assign r1toalu      = r1_q;
    assign r2tobuff_alu = r2_q;
    assign resulttoreg  = alu_c;

    // Bus is released whenever the controller does not select the result
    assign bus = aluOutEn ? r2_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_toplevel_alu.sv
// Directed-vector bench for toplevel_alu: stimulus queues expected observations,
// a negedge monitor pops and compares them against the DUT.
module tb_toplevel_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0en, r1en, r2en, aluOutEn;
    logic [2:0]  ALU_Sel;
    logic [15:0] r0toalu, r1toalu, resulttoreg, r2tobuff_alu;
    wire  [15:0] bus;
    logic [15:0] drv_val;
    logic        drv_en;

    assign bus = drv_en ? drv_val : 16'hzzzz;

    toplevel_alu dut (
        .clk          (clk),
        .rst          (rst),
        .r0en         (r0en),
        .r1en         (r1en),
        .r0toalu      (r0toalu),
        .r1toalu      (r1toalu),
        .ALU_Sel      (ALU_Sel),
        .resulttoreg  (resulttoreg),
        .r2en         (r2en),
        .r2tobuff_alu (r2tobuff_alu),
        .bus          (bus),
        .aluOutEn     (aluOutEn)
    );

    always #5 clk = ~clk;

    localparam int SIG_R0  = 0;
    localparam int SIG_R1  = 1;
    localparam int SIG_RES = 2;
    localparam int SIG_R2  = 3;
    localparam int SIG_BUS = 4;

    typedef struct {
        int          sig;
        int          tag;
        logic [15:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_n  = 0;

    function automatic string sig_name(input int s);
        case (s)
            SIG_R0:  return "r0toalu";
            SIG_R1:  return "r1toalu";
            SIG_RES: return "resulttoreg";
            SIG_R2:  return "r2tobuff_alu";
            default: return "bus";
        endcase
    endfunction

    function automatic logic [15:0] sample(input int s);
        case (s)
            SIG_R0:  return r0toalu;
            SIG_R1:  return r1toalu;
            SIG_RES: return resulttoreg;
            SIG_R2:  return r2tobuff_alu;
            default: return bus;
        endcase
    endfunction

    // Monitor: every expectation queued since the last falling edge is checked here
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [15:0] act;
                e   = q.pop_front();
                act = sample(e.sig);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s#%0d actual=%h expected=%h", sig_name(e.sig), e.tag, act, e.exp);
                end
            end
        end
    end

    task automatic expect_v(input int s, input logic [15:0] v);
        exp_t e;
        e.sig = s;
        e.tag = tag_n;
        e.exp = v;
        tag_n++;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v, input logic l0, input logic l1);
        drv_val = v;
        drv_en  = 1'b1;
        r0en    = l0;
        r1en    = l1;
        tick();
        r0en    = 1'b0;
        r1en    = 1'b0;
        drv_en  = 1'b0;
    endtask

    logic [15:0] sweep [8];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        sweep = '{16'h8004, 16'h7FFE, 16'h0001, 16'h8003,
                  16'h8002, 16'h7FFE, 16'h0002, 16'h4000};
        rst = 1'b1; r0en = 1'b0; r1en = 1'b0; r2en = 1'b0; aluOutEn = 1'b0;
        ALU_Sel = 3'b000; drv_val = '0; drv_en = 1'b0;
        tick();
        rst = 1'b0;

        // Reset after arbitrary loads
        load(16'h1111, 1'b1, 1'b1);
        r2en = 1'b1;
        tick();
        r2en = 1'b0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        expect_v(SIG_R0, 16'h0000);
        expect_v(SIG_R1, 16'h0000);
        expect_v(SIG_R2, 16'h0000);
        expect_v(SIG_RES, 16'h0000);
        tick();
        ALU_Sel = 3'b101;
        expect_v(SIG_RES, 16'hFFFF);
        tick();

        // Load and add, then drive result onto the bus
        load(16'h1234, 1'b1, 1'b0);
        load(16'h0F0F, 1'b0, 1'b1);
        ALU_Sel = 3'b000;
        expect_v(SIG_R0, 16'h1234);
        expect_v(SIG_R1, 16'h0F0F);
        expect_v(SIG_RES, 16'h2143);
        r2en = 1'b1;
        tick();
        r2en     = 1'b0;
        aluOutEn = 1'b1;
        expect_v(SIG_R2, 16'h2143);
        expect_v(SIG_BUS, 16'h2143);
        tick();
        aluOutEn = 1'b0;

        // Opcode sweep
        load(16'h8001, 1'b1, 1'b0);
        load(16'h0003, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            ALU_Sel = 3'(i);
            expect_v(SIG_RES, sweep[i]);
            tick();
        end

        // Wrap-around
        load(16'hFFFF, 1'b1, 1'b0);
        load(16'h0001, 1'b0, 1'b1);
        ALU_Sel = 3'b000;
        expect_v(SIG_RES, 16'h0000);
        tick();
        load(16'h0000, 1'b1, 1'b0);
        ALU_Sel = 3'b001;
        expect_v(SIG_RES, 16'hFFFF);
        tick();

        // R2 to R1 transfer over the bus, then R2 hold
        load(16'h00AA, 1'b1, 1'b0);
        load(16'h0000, 1'b0, 1'b1);
        ALU_Sel = 3'b000;
        r2en = 1'b1;
        tick();
        r2en     = 1'b0;
        aluOutEn = 1'b1;
        r1en     = 1'b1;
        tick();
        r1en = 1'b0;
        expect_v(SIG_R1, 16'h00AA);
        expect_v(SIG_BUS, 16'h00AA);
        tick();
        aluOutEn = 1'b0;
        drv_val  = 16'h5500;
        drv_en   = 1'b1;
        r0en     = 1'b1;
        tick();
        r0en = 1'b0;
        expect_v(SIG_R0, 16'h5500);
        expect_v(SIG_R2, 16'h00AA);
        expect_v(SIG_BUS, 16'h5500);
        tick();
        drv_en = 1'b0;
        load(16'h0101, 1'b0, 1'b1);
        expect_v(SIG_R1, 16'h0101);
        expect_v(SIG_R2, 16'h00AA);
        expect_v(SIG_RES, 16'h5601);
        tick();

        // Reset priority over pending loads
        drv_val = 16'h5555;
        drv_en  = 1'b1;
        r0en    = 1'b1;
        r2en    = 1'b1;
        rst     = 1'b1;
        tick();
        rst = 1'b0; r0en = 1'b0; r2en = 1'b0; drv_en = 1'b0;
        expect_v(SIG_R0, 16'h0000);
        expect_v(SIG_R1, 16'h0000);
        expect_v(SIG_R2, 16'h0000);
        tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
